// File: rtl/simt_writeback_arb.sv
// SIMT writeback arbiter: buffers lane-vector results per source, grants one per
// cycle round-robin, and drives the register-file write port plus scoreboard release.

package pkg_opengpu;
    localparam int unsigned WARP_SIZE      = 32;
    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned WARP_ID_WIDTH  = 5;
    localparam int unsigned REG_ADDR_WIDTH = 5;
endpackage

module simt_writeback_arb
    import pkg_opengpu::*;
#(
    parameter int unsigned NUM_SRC    = 3,
    parameter int unsigned NUM_LANES  = WARP_SIZE,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [NUM_SRC-1:0]                                src_valid,
    output logic [NUM_SRC-1:0]                                src_ready,
    input  logic [NUM_SRC-1:0][WARP_ID_WIDTH-1:0]             src_warp_id,
    input  logic [NUM_SRC-1:0][REG_ADDR_WIDTH-1:0]            src_rd_addr,
    input  logic [NUM_SRC-1:0][NUM_LANES-1:0][DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0][NUM_LANES-1:0]                 src_mask,
    output logic                                              rd_we,
    output logic [WARP_ID_WIDTH-1:0]                          rd_warp_id,
    output logic [REG_ADDR_WIDTH-1:0]                         rd_addr,
    output logic [NUM_LANES-1:0][DATA_WIDTH-1:0]              rd_data,
    output logic [NUM_LANES-1:0]                              rd_mask,
    output logic                                              rel_valid,
    output logic [WARP_ID_WIDTH-1:0]                          rel_warp_id,
    output logic [REG_ADDR_WIDTH-1:0]                         rel_rd_addr,
    output logic                                              busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef struct packed {
        logic [WARP_ID_WIDTH-1:0]             warp_id;
        logic [REG_ADDR_WIDTH-1:0]            rd_addr;
        logic [NUM_LANES-1:0][DATA_WIDTH-1:0] data;
        logic [NUM_LANES-1:0]                 mask;
    } wb_entry_t;

    wb_entry_t        mem_q     [NUM_SRC][FIFO_DEPTH];
    wb_entry_t        src_entry [NUM_SRC];
    wb_entry_t        head      [NUM_SRC];
    wb_entry_t        gnt_entry;

    logic [PTR_W-1:0] wr_ptr_q  [NUM_SRC];
    logic [PTR_W-1:0] wr_ptr_d  [NUM_SRC];
    logic [PTR_W-1:0] rd_ptr_q  [NUM_SRC];
    logic [PTR_W-1:0] rd_ptr_d  [NUM_SRC];
    logic [CNT_W-1:0] count_q   [NUM_SRC];
    logic [CNT_W-1:0] count_d   [NUM_SRC];

    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] ready_d;
    logic [SRC_W-1:0]   rr_ptr_q;
    logic [SRC_W-1:0]   rr_ptr_d;
    logic [SRC_W-1:0]   gnt_idx;
    logic [SRC_W-1:0]   scan;
    logic               grant;
    logic               rd_we_d;
    logic               busy_d;

    // Pack incoming fields and expose each FIFO head.
    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src_entry[i].warp_id = src_warp_id[i];
            src_entry[i].rd_addr = src_rd_addr[i];
            src_entry[i].data    = src_data[i];
            src_entry[i].mask    = src_mask[i];
            head[i]              = mem_q[i][rd_ptr_q[i]];
        end
    end

    // Round-robin scan starting at rr_ptr; first non-empty FIFO wins.
    always_comb begin
        grant   = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        pop     = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            scan = SRC_W'((32'(rr_ptr_q) + k) % NUM_SRC);
            if (!grant && (count_q[scan] != '0)) begin
                grant   = 1'b1;
                gnt_idx = scan;
            end
        end
        if (grant) begin
            pop[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        gnt_entry = head[gnt_idx];
        rd_we_d   = 1'b0;
        if (grant) begin
            rr_ptr_d = SRC_W'((32'(gnt_idx) + 32'd1) % NUM_SRC);
            rd_we_d  = (gnt_entry.rd_addr != '0) && (|gnt_entry.mask);
        end
    end

    // Pointer/count next state; ready is re-derived from the next count so it
    // stays a pure register with no pop-to-ready path.
    always_comb begin
        push     = '0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ready_d  = '0;
        busy_d   = grant;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            push[i]     = src_valid[i] && src_ready[i];
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
            count_d[i]  = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            ready_d[i]  = (count_d[i] != CNT_W'(FIFO_DEPTH));
            if (count_d[i] != '0) begin
                busy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '{default: '0};
            rd_ptr_q    <= '{default: '0};
            count_q     <= '{default: '0};
            src_ready   <= '1;
            rr_ptr_q    <= '0;
            rd_we       <= 1'b0;
            rd_warp_id  <= '0;
            rd_addr     <= '0;
            rd_data     <= '0;
            rd_mask     <= '0;
            rel_valid   <= 1'b0;
            rel_warp_id <= '0;
            rel_rd_addr <= '0;
            busy        <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            src_ready <= ready_d;
            rr_ptr_q  <= rr_ptr_d;
            rd_we     <= rd_we_d;
            rel_valid <= grant;
            busy      <= busy_d;
            if (grant) begin
                rd_warp_id  <= gnt_entry.warp_id;
                rd_addr     <= gnt_entry.rd_addr;
                rd_data     <= gnt_entry.data;
                rd_mask     <= gnt_entry.mask;
                rel_warp_id <= gnt_entry.warp_id;
                rel_rd_addr <= gnt_entry.rd_addr;
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the counts.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= src_entry[i];
            end
        end
    end

endmodule

// File: tb/tb_simt_writeback_arb.sv
// Scoreboard bench for simt_writeback_arb: directed pushes queue expected writes,
// a negedge monitor pops and compares every release and models the register file.

module tb_simt_writeback_arb;
    import pkg_opengpu::*;

    localparam int unsigned NS = 3;
    localparam int unsigned NL = WARP_SIZE;
    localparam int unsigned NW = 2 ** WARP_ID_WIDTH;
    localparam int unsigned NR = 2 ** REG_ADDR_WIDTH;

    typedef logic [NL-1:0][DATA_WIDTH-1:0] lanes_t;

    typedef struct {
        logic                      we;
        logic [WARP_ID_WIDTH-1:0]  warp;
        logic [REG_ADDR_WIDTH-1:0] addr;
        lanes_t                    data;
        logic [NL-1:0]             mask;
    } exp_t;

    logic                                       clk;
    logic                                       rst;
    logic [NS-1:0]                              src_valid;
    logic [NS-1:0]                              src_ready;
    logic [NS-1:0][WARP_ID_WIDTH-1:0]           src_warp_id;
    logic [NS-1:0][REG_ADDR_WIDTH-1:0]          src_rd_addr;
    logic [NS-1:0][NL-1:0][DATA_WIDTH-1:0]      src_data;
    logic [NS-1:0][NL-1:0]                      src_mask;
    logic                                       rd_we;
    logic [WARP_ID_WIDTH-1:0]                   rd_warp_id;
    logic [REG_ADDR_WIDTH-1:0]                  rd_addr;
    lanes_t                                     rd_data;
    logic [NL-1:0]                              rd_mask;
    logic                                       rel_valid;
    logic [WARP_ID_WIDTH-1:0]                   rel_warp_id;
    logic [REG_ADDR_WIDTH-1:0]                  rel_rd_addr;
    logic                                       busy;

    exp_t            exp_q[$];
    exp_t            mon_e;
    int              n_checks = 0;
    int              n_fail   = 0;
    int              ev_cnt   = 0;
    int              cur_run  = 0;
    int              max_run  = 0;
    int              sent [NS];
    logic [NS-1:0]   rdy_hist [16];
    logic [DATA_WIDTH-1:0] rf [NW][NR][NL];

    simt_writeback_arb #(
        .NUM_SRC    (NS),
        .NUM_LANES  (NL),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_warp_id (src_warp_id),
        .src_rd_addr (src_rd_addr),
        .src_data    (src_data),
        .src_mask    (src_mask),
        .rd_we       (rd_we),
        .rd_warp_id  (rd_warp_id),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_mask     (rd_mask),
        .rel_valid   (rel_valid),
        .rel_warp_id (rel_warp_id),
        .rel_rd_addr (rel_rd_addr),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic check_w(input string name, input lanes_t act, input lanes_t req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic lanes_t item_data(input int ph, input int s, input int j);
        lanes_t d;
        for (int k = 0; k < NL; k++) d[k] = {8'(ph), 8'(s), 8'(j), 8'(k)};
        return d;
    endfunction

    function automatic exp_t mk_exp(input logic we, input int w, input int a,
                                    input lanes_t d, input logic [NL-1:0] m);
        exp_t e;
        e.we   = we;
        e.warp = WARP_ID_WIDTH'(w);
        e.addr = REG_ADDR_WIDTH'(a);
        e.data = d;
        e.mask = m;
        return e;
    endfunction

    function automatic exp_t stream_exp(input int ph, input int s, input int j);
        return mk_exp(1'b1, s * 8 + j, j + 1, item_data(ph, s, j), '1);
    endfunction

    // Monitor: every release pops one expected write; accepted writes update the RF model.
    always @(negedge clk) begin
        if (!rst) begin
            if (rel_valid) begin
                ev_cnt++;
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
                check("release_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("rd_we", 64'(rd_we), 64'(mon_e.we));
                    check("rel_warp_id", 64'(rel_warp_id), 64'(mon_e.warp));
                    check("rel_rd_addr", 64'(rel_rd_addr), 64'(mon_e.addr));
                    check("rd_warp_id", 64'(rd_warp_id), 64'(mon_e.warp));
                    check("rd_addr", 64'(rd_addr), 64'(mon_e.addr));
                    check("rd_mask", 64'(rd_mask), 64'(mon_e.mask));
                    check_w("rd_data", rd_data, mon_e.data);
                end
            end else begin
                cur_run = 0;
            end
            if (rd_we) begin
                check("we_has_release", 64'(rel_valid), 64'(1));
                for (int k = 0; k < NL; k++) begin
                    if (rd_mask[k]) rf[rd_warp_id][rd_addr][k] = rd_data[k];
                end
            end
        end
    end

    task automatic idle_inputs();
        src_valid   = '0;
        src_warp_id = '0;
        src_rd_addr = '0;
        src_data    = '0;
        src_mask    = '0;
    endtask

    task automatic drive(input int s, input int w, input int a, input lanes_t d,
                         input logic [NL-1:0] m);
        src_warp_id[s] = WARP_ID_WIDTH'(w);
        src_rd_addr[s] = REG_ADDR_WIDTH'(a);
        src_data[s]    = d;
        src_mask[s]    = m;
        src_valid[s]   = 1'b1;
    endtask

    // Single-cycle push; called just after a rising edge.
    task automatic push_one(input int s, input int w, input int a, input lanes_t d,
                            input logic [NL-1:0] m);
        check("ready_before_push", 64'(src_ready[s]), 64'(1));
        drive(s, w, a, d, m);
        @(posedge clk);
        #1;
        src_valid[s] = 1'b0;
    endtask

    // Each source offers consecutive items, advancing only on a handshake.
    task automatic run_streams(input int ph, input int lim0, input int lim1,
                               input int lim2, input int window);
        int            lim [NS];
        logic [NS-1:0] rdy_now;
        logic [NS-1:0] vld;
        lim[0] = lim0;
        lim[1] = lim1;
        lim[2] = lim2;
        for (int s = 0; s < NS; s++) sent[s] = 0;
        for (int c = 0; c < window; c++) begin
            rdy_now     = src_ready;
            rdy_hist[c] = rdy_now;
            for (int s = 0; s < NS; s++) begin
                vld[s] = (sent[s] < lim[s]);
                if (vld[s]) drive(s, s * 8 + sent[s], sent[s] + 1, item_data(ph, s, sent[s]), '1);
                else src_valid[s] = 1'b0;
            end
            @(posedge clk);
            #1;
            for (int s = 0; s < NS; s++) begin
                if (vld[s] && rdy_now[s]) sent[s]++;
            end
        end
        src_valid = '0;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            @(posedge clk);
            budget++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", 64'(busy), 64'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        lanes_t d_single;
        lanes_t d_a;
        lanes_t d_b;
        lanes_t rf_act;
        lanes_t rf_req;
        int     cnt [NS];
        int     bp_order [15];
        int     ev_snap;

        bp_order = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 2, 0};
        for (int k = 0; k < NL; k++) begin
            d_single[k] = DATA_WIDTH'(k + 100);
            d_a[k]      = {16'hAAAA, 16'(k)};
            d_b[k]      = {16'h5555, 16'(k)};
        end

        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rd_we", 64'(rd_we), 64'(0));
        check("reset_rel_valid", 64'(rel_valid), 64'(0));
        check("reset_rd_warp_id", 64'(rd_warp_id), 64'(0));
        check("reset_rd_addr", 64'(rd_addr), 64'(0));
        check("reset_rd_mask", 64'(rd_mask), 64'(0));
        check_w("reset_rd_data", rd_data, '0);
        check("reset_rel_warp_id", 64'(rel_warp_id), 64'(0));
        check("reset_rel_rd_addr", 64'(rel_rd_addr), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_src_ready", 64'(src_ready), 64'(3'b111));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single result: granted the cycle after the push, write visible after E1.
        exp_q.push_back(mk_exp(1'b1, 2, 7, d_single, '1));
        push_one(0, 2, 7, d_single, '1);
        check("single_we_after_E0", 64'(rd_we), 64'(0));
        check("single_busy_after_E0", 64'(busy), 64'(1));
        @(posedge clk);
        #1;
        check("single_we_after_E1", 64'(rd_we), 64'(1));
        check("single_rel_after_E1", 64'(rel_valid), 64'(1));
        check("single_rel_warp", 64'(rel_warp_id), 64'(2));
        check("single_rel_rd", 64'(rel_rd_addr), 64'(7));
        @(posedge clk);
        #1;
        check("single_we_pulse", 64'(rd_we), 64'(0));
        wait_drain();

        // x0 destination and empty mask: release without write.
        exp_q.push_back(mk_exp(1'b0, 4, 0, item_data(3, 2, 0), '1));
        exp_q.push_back(mk_exp(1'b0, 4, 5, item_data(3, 2, 1), '0));
        push_one(2, 4, 0, item_data(3, 2, 0), '1);
        push_one(2, 4, 5, item_data(3, 2, 1), '0);
        wait_drain();

        // Partial mask: only lanes 0-15 take the second write.
        exp_q.push_back(mk_exp(1'b1, 3, 9, d_a, '1));
        exp_q.push_back(mk_exp(1'b1, 3, 9, d_b, NL'(32'h0000_FFFF)));
        push_one(1, 3, 9, d_a, '1);
        push_one(1, 3, 9, d_b, NL'(32'h0000_FFFF));
        wait_drain();
        for (int k = 0; k < NL; k++) begin
            rf_act[k] = rf[3][9][k];
            rf_req[k] = (k < 16) ? d_b[k] : d_a[k];
        end
        check_w("partial_rf_lanes", rf_act, rf_req);

        // Mid-stream reset discards buffered results.
        drive(0, 1, 1, item_data(9, 0, 0), '1);
        drive(1, 1, 2, item_data(9, 1, 0), '1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        check("prereset_we", 64'(rd_we), 64'(1));
        check("prereset_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        idle_inputs();
        #1;
        check("midreset_rd_we", 64'(rd_we), 64'(0));
        check("midreset_rel_valid", 64'(rel_valid), 64'(0));
        check("midreset_src_ready", 64'(src_ready), 64'(3'b111));
        check("midreset_busy", 64'(busy), 64'(0));
        ev_snap = ev_cnt;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("no_stale_release", 64'(ev_cnt), 64'(ev_snap));
        check("postreset_busy", 64'(busy), 64'(0));
        check("postreset_src_ready", 64'(src_ready), 64'(3'b111));

        // Fairness: all sources saturate for 12 cycles; strict 0,1,2 rotation.
        max_run = 0;
        for (int s = 0; s < NS; s++) cnt[s] = 0;
        for (int n = 0; n < 16; n++) begin
            exp_q.push_back(stream_exp(1, n % 3, cnt[n % 3]));
            cnt[n % 3]++;
        end
        run_streams(1, 99, 99, 99, 12);
        check("fair_sent0", 64'(sent[0]), 64'(6));
        check("fair_sent1", 64'(sent[1]), 64'(5));
        check("fair_sent2", 64'(sent[2]), 64'(5));
        check("fair_ready_c1", 64'(rdy_hist[1]), 64'(3'b111));
        check("fair_ready_c2", 64'(rdy_hist[2]), 64'(3'b001));
        check("fair_ready_c3", 64'(rdy_hist[3]), 64'(3'b010));
        wait_drain();
        check("fair_no_gaps", 64'(max_run), 64'(16));

        // Backpressure: src1 offers 4 items while src0/src2 saturate.
        do_reset();
        for (int s = 0; s < NS; s++) cnt[s] = 0;
        for (int n = 0; n < 15; n++) begin
            exp_q.push_back(stream_exp(2, bp_order[n], cnt[bp_order[n]]));
            cnt[bp_order[n]]++;
        end
        run_streams(2, 99, 4, 99, 12);
        check("bp_sent0", 64'(sent[0]), 64'(6));
        check("bp_sent1", 64'(sent[1]), 64'(4));
        check("bp_sent2", 64'(sent[2]), 64'(5));
        check("bp_src1_full_not_ready", 64'(rdy_hist[2][1]), 64'(0));
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
